// File: rtl/fpu_writeback_scoreboard.sv
// Merges fixed-latency FPU results and handshaked load results onto one registered RF write port and tracks a busy scoreboard for issue hazards.
// Optional commit-write forwarding is enabled by defining FPU_WB_BYPASS_EN.
module fpu_writeback_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          issue_valid_i,
   input  logic [$clog2(NUM_REGS)-1:0]   issue_dest_i,
   input  logic [$clog2(NUM_REGS)-1:0]   src1_i,
   input  logic [$clog2(NUM_REGS)-1:0]   src2_i,
   output logic                          hazard_o,
   input  logic                          fpu_wb_valid_i,
   input  logic [$clog2(NUM_REGS)-1:0]   fpu_wb_dest_i,
   input  logic [DATA_WIDTH-1:0]         fpu_wb_data_i,
   input  logic                          ld_wb_valid_i,
   output logic                          ld_wb_ready_o,
   input  logic [$clog2(NUM_REGS)-1:0]   ld_wb_dest_i,
   input  logic [DATA_WIDTH-1:0]         ld_wb_data_i,
   output logic                          rf_we_o,
   output logic [$clog2(NUM_REGS)-1:0]   rf_waddr_o,
   output logic [DATA_WIDTH-1:0]         rf_wdata_o,
   output logic                          byp1_hit_o,
   output logic                          byp2_hit_o,
   output logic [DATA_WIDTH-1:0]         byp_data_o,
   output logic                          error_o
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_nxt;
   logic                  accept;
   logic [AW-1:0]         win_dest;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  issue_err;
   logic                  commit_err;

   // FPU cannot stall, so it always wins; a held-off load simply waits.
   assign ld_wb_ready_o = !fpu_wb_valid_i;

   always_comb begin
      accept   = fpu_wb_valid_i | ld_wb_valid_i;
      win_dest = ld_wb_dest_i;
      win_data = ld_wb_data_i;
      if (fpu_wb_valid_i) begin
         win_dest = fpu_wb_dest_i;
         win_data = fpu_wb_data_i;
      end
   end

   // Clear applied first so a same-cycle issue to the committing register keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (rf_we_o)
         busy_nxt[rf_waddr_o] = 1'b0;
      if (issue_valid_i)
         busy_nxt[issue_dest_i] = 1'b1;
   end

   assign issue_err  = issue_valid_i & busy[issue_dest_i] &
                       !(rf_we_o & (rf_waddr_o == issue_dest_i));
   assign commit_err = rf_we_o & !busy[rf_waddr_o];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy       <= '0;
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
         error_o    <= 1'b0;
      end else begin
         busy    <= busy_nxt;
         rf_we_o <= accept;
         if (accept) begin
            rf_waddr_o <= win_dest;
            rf_wdata_o <= win_data;
         end
         if (issue_err | commit_err)
            error_o <= 1'b1;
      end
   end

`ifdef FPU_WB_BYPASS_EN
   assign byp1_hit_o = rf_we_o & (rf_waddr_o == src1_i);
   assign byp2_hit_o = rf_we_o & (rf_waddr_o == src2_i);
   assign byp_data_o = rf_wdata_o;
`else
   assign byp1_hit_o = 1'b0;
   assign byp2_hit_o = 1'b0;
   assign byp_data_o = '0;
`endif

   assign hazard_o = (busy[src1_i] & !byp1_hit_o) | (busy[src2_i] & !byp2_hit_o);

endmodule

// File: tb/tb_fpu_writeback_scoreboard.sv
// Bench for fpu_writeback_scoreboard: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fpu_writeback_scoreboard;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        issue_valid_i;
   logic [5:0]  issue_dest_i;
   logic [5:0]  src1_i;
   logic [5:0]  src2_i;
   logic        hazard_o;
   logic        fpu_wb_valid_i;
   logic [5:0]  fpu_wb_dest_i;
   logic [31:0] fpu_wb_data_i;
   logic        ld_wb_valid_i;
   logic        ld_wb_ready_o;
   logic [5:0]  ld_wb_dest_i;
   logic [31:0] ld_wb_data_i;
   logic        rf_we_o;
   logic [5:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        byp1_hit_o;
   logic        byp2_hit_o;
   logic [31:0] byp_data_o;
   logic        error_o;

   int checks = 0;
   int errors = 0;

   // Reference model: register busy flags, the write expected on the RF port, sticky error.
   bit          m_busy [64];
   bit          m_we;
   logic [5:0]  m_waddr;
   logic [31:0] m_wdata;
   bit          m_err;

   fpu_writeback_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_dest_i(issue_dest_i),
      .src1_i(src1_i), .src2_i(src2_i), .hazard_o(hazard_o),
      .fpu_wb_valid_i(fpu_wb_valid_i), .fpu_wb_dest_i(fpu_wb_dest_i), .fpu_wb_data_i(fpu_wb_data_i),
      .ld_wb_valid_i(ld_wb_valid_i), .ld_wb_ready_o(ld_wb_ready_o),
      .ld_wb_dest_i(ld_wb_dest_i), .ld_wb_data_i(ld_wb_data_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .byp1_hit_o(byp1_hit_o), .byp2_hit_o(byp2_hit_o), .byp_data_o(byp_data_o),
      .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_err   = 1'b0;
   endtask

   // One clock edge of the architectural rules: errors judged on pre-edge state,
   // the committing register retires, the issued register becomes busy, the winner is written next.
   task automatic model_update();
      if (issue_valid_i && m_busy[issue_dest_i] && !(m_we && m_waddr == issue_dest_i)) m_err = 1'b1;
      if (m_we && !m_busy[m_waddr]) m_err = 1'b1;
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (issue_valid_i) m_busy[issue_dest_i] = 1'b1;
      if (fpu_wb_valid_i) begin
         m_we = 1'b1; m_waddr = fpu_wb_dest_i; m_wdata = fpu_wb_data_i;
      end else if (ld_wb_valid_i) begin
         m_we = 1'b1; m_waddr = ld_wb_dest_i; m_wdata = ld_wb_data_i;
      end else begin
         m_we = 1'b0;
      end
   endtask

   function automatic bit exp_hit(input logic [5:0] s);
`ifdef FPU_WB_BYPASS_EN
      return m_we && (m_waddr == s);
`else
      return 1'b0 && (s == s);
`endif
   endfunction

   function automatic bit exp_hazard();
      return (m_busy[src1_i] && !exp_hit(src1_i)) || (m_busy[src2_i] && !exp_hit(src2_i));
   endfunction

   task automatic tick();
      @(posedge clk_i);
      if (rst_ni) model_update();
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid_i  = 1'b0; issue_dest_i = '0;
      src1_i = '0; src2_i = '0;
      fpu_wb_valid_i = 1'b0; fpu_wb_dest_i = '0; fpu_wb_data_i = '0;
      ld_wb_valid_i  = 1'b0; ld_wb_dest_i  = '0; ld_wb_data_i  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      model_reset();
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      model_reset();
      #3;
      src1_i = 6'h05; src2_i = 6'h22;
      #1;
      checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", rf_we_o); end
      checks++; if (rf_waddr_o !== 6'h00) begin errors++; $display("FAIL reset_waddr got %h want 00", rf_waddr_o); end
      checks++; if (rf_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", error_o); end
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", hazard_o); end
      checks++; if ({byp1_hit_o, byp2_hit_o} !== 2'b00) begin errors++; $display("FAIL reset_byp_hit got %b want 00", {byp1_hit_o, byp2_hit_o}); end
      checks++; if (byp_data_o !== 32'h0) begin errors++; $display("FAIL reset_byp_data got %h want 0", byp_data_o); end
      checks++; if (ld_wb_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %0b want 1", ld_wb_ready_o); end
      do_reset();
   endtask

   task automatic test_raw_hazard();
      do_reset();
      issue_valid_i = 1'b1; issue_dest_i = 6'h05;
      tick();
      issue_valid_i = 1'b0; src1_i = 6'h05;
      for (int c = 1; c <= 3; c++) begin
         #1;
         checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL raw_hazard_c%0d got %0b want 1", c, hazard_o); end
         tick();
      end
      fpu_wb_valid_i = 1'b1; fpu_wb_dest_i = 6'h05; fpu_wb_data_i = 32'h3F800000;
      #1;
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL raw_hazard_c4 got %0b want 1", hazard_o); end
      tick();
      fpu_wb_valid_i = 1'b0;
      #1;
      checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL raw_we_c5 got %0b want 1", rf_we_o); end
      checks++; if (rf_waddr_o !== 6'h05) begin errors++; $display("FAIL raw_waddr_c5 got %h want 05", rf_waddr_o); end
      checks++; if (rf_wdata_o !== 32'h3F800000) begin errors++; $display("FAIL raw_wdata_c5 got %h want 3f800000", rf_wdata_o); end
`ifdef FPU_WB_BYPASS_EN
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL raw_hazard_c5 got %0b want 0", hazard_o); end
      checks++; if (byp1_hit_o !== 1'b1) begin errors++; $display("FAIL raw_byp1_c5 got %0b want 1", byp1_hit_o); end
      checks++; if (byp_data_o !== 32'h3F800000) begin errors++; $display("FAIL raw_bypdata_c5 got %h want 3f800000", byp_data_o); end
`else
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL raw_hazard_c5 got %0b want 1", hazard_o); end
      checks++; if (byp1_hit_o !== 1'b0) begin errors++; $display("FAIL raw_byp1_c5 got %0b want 0", byp1_hit_o); end
`endif
      tick();
      #1;
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL raw_hazard_c6 got %0b want 0", hazard_o); end
      checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL raw_we_c6 got %0b want 0", rf_we_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL raw_error got %0b want 0", error_o); end
   endtask

   task automatic test_arbitration();
      do_reset();
      issue_valid_i = 1'b1; issue_dest_i = 6'h21; tick();
      issue_dest_i = 6'h02; tick();
      issue_valid_i = 1'b0;
      fpu_wb_valid_i = 1'b1; fpu_wb_dest_i = 6'h21; fpu_wb_data_i = 32'hAAAA0021;
      ld_wb_valid_i  = 1'b1; ld_wb_dest_i  = 6'h02; ld_wb_data_i  = 32'h55550002;
      #1;
      checks++; if (ld_wb_ready_o !== 1'b0) begin errors++; $display("FAIL arb_ready_blocked got %0b want 0", ld_wb_ready_o); end
      tick();
      fpu_wb_valid_i = 1'b0;
      #1;
      checks++; if (ld_wb_ready_o !== 1'b1) begin errors++; $display("FAIL arb_ready_free got %0b want 1", ld_wb_ready_o); end
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 6'h21 || rf_wdata_o !== 32'hAAAA0021) begin
         errors++; $display("FAIL arb_first_commit got we=%0b %h/%h want 1 21/aaaa0021", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      ld_wb_valid_i = 1'b0;
      #1;
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 6'h02 || rf_wdata_o !== 32'h55550002) begin
         errors++; $display("FAIL arb_second_commit got we=%0b %h/%h want 1 02/55550002", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      #1;
      checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL arb_idle_we got %0b want 0", rf_we_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL arb_error got %0b want 0", error_o); end
   endtask

   task automatic test_set_clear_same();
      do_reset();
      issue_valid_i = 1'b1; issue_dest_i = 6'h07; tick();
      issue_valid_i = 1'b0;
      fpu_wb_valid_i = 1'b1; fpu_wb_dest_i = 6'h07; fpu_wb_data_i = 32'h12345678; tick();
      fpu_wb_valid_i = 1'b0;
      issue_valid_i = 1'b1; issue_dest_i = 6'h07;
      #1;
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 6'h07) begin errors++; $display("FAIL same_commit got we=%0b addr=%h want 1 07", rf_we_o, rf_waddr_o); end
      tick();
      issue_valid_i = 1'b0; src1_i = 6'h07;
      #1;
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL same_busy_kept got %0b want 1", hazard_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL same_error got %0b want 0", error_o); end
   endtask

   task automatic test_double_issue();
      do_reset();
      issue_valid_i = 1'b1; issue_dest_i = 6'h10; tick();
      #1;
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL dbl_error_first got %0b want 0", error_o); end
      tick();
      issue_valid_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL dbl_error_held%0d got %0b want 1", c, error_o); end
         tick();
      end
      rst_ni = 1'b0;
      model_reset();
      #1;
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL dbl_error_reset got %0b want 0", error_o); end
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_load_nonbusy();
      do_reset();
      ld_wb_valid_i = 1'b1; ld_wb_dest_i = 6'h30; ld_wb_data_i = 32'hCAFEF00D; tick();
      ld_wb_valid_i = 1'b0;
      #1;
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 6'h30) begin errors++; $display("FAIL nb_commit got we=%0b addr=%h want 1 30", rf_we_o, rf_waddr_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL nb_error_early got %0b want 0", error_o); end
      tick();
      #1;
      checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL nb_error_after got %0b want 1", error_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_valid_i = 1'b1; issue_dest_i = 6'h00; tick();
      issue_dest_i = 6'h01; tick();
      issue_valid_i = 1'b0;
      fpu_wb_valid_i = 1'b1; fpu_wb_dest_i = 6'h01; fpu_wb_data_i = 32'hDEADBEEF; tick();
      fpu_wb_valid_i = 1'b0; src1_i = 6'h00; src2_i = 6'h01;
      #1;
      checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL mid_pending got %0b want 1", rf_we_o); end
      rst_ni = 1'b0;
      model_reset();
      #1;
      checks++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 6'h00 || rf_wdata_o !== 32'h0) begin
         errors++; $display("FAIL mid_rf_reset got we=%0b %h/%h want 0 00/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL mid_hazard got %0b want 0", hazard_o); end
      checks++; if (error_o !== 1'b0 || byp1_hit_o !== 1'b0 || byp2_hit_o !== 1'b0 || byp_data_o !== 32'h0) begin
         errors++; $display("FAIL mid_misc got err=%0b hits=%0b%0b byp=%h want 0 00 0", error_o, byp1_hit_o, byp2_hit_o, byp_data_o); end
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL mid_no_write%0d got %0b want 0", c, rf_we_o); end
         checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL mid_clear%0d got %0b want 0", c, hazard_o); end
      end
   endtask

   task automatic test_random();
      logic [5:0] inflight[$];
      logic [5:0] d;
      bit         ld_hold;
      bit         ld_taken;
      bit         issued;
      int         idx;
      do_reset();
      ld_hold = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         issue_valid_i = 1'b0; issued = 1'b0;
         fpu_wb_valid_i = 1'b0;
         d = 6'($urandom);
         if ($urandom_range(0, 2) != 0 && !m_busy[d]) begin
            issue_valid_i = 1'b1; issue_dest_i = d; issued = 1'b1;
         end
         if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, inflight.size() - 1);
            fpu_wb_valid_i = 1'b1; fpu_wb_dest_i = inflight[idx]; fpu_wb_data_i = $urandom;
            inflight.delete(idx);
         end
         if (!ld_hold && inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, inflight.size() - 1);
            ld_wb_valid_i = 1'b1; ld_wb_dest_i = inflight[idx]; ld_wb_data_i = $urandom;
            inflight.delete(idx);
            ld_hold = 1'b1;
         end
         src1_i = (inflight.size() > 0 && $urandom_range(0, 1) == 0) ? inflight[0] : 6'($urandom);
         src2_i = m_we ? m_waddr : 6'($urandom);
         #1;
         checks++; if (hazard_o !== exp_hazard()) begin errors++; $display("FAIL rnd_hazard cyc%0d got %0b want %0b", cyc, hazard_o, exp_hazard()); end
         checks++; if (ld_wb_ready_o !== !fpu_wb_valid_i) begin errors++; $display("FAIL rnd_ready cyc%0d got %0b want %0b", cyc, ld_wb_ready_o, !fpu_wb_valid_i); end
         checks++; if (rf_we_o !== m_we) begin errors++; $display("FAIL rnd_we cyc%0d got %0b want %0b", cyc, rf_we_o, m_we); end
         if (m_we) begin
            checks++; if (rf_waddr_o !== m_waddr || rf_wdata_o !== m_wdata) begin
               errors++; $display("FAIL rnd_write cyc%0d got %h/%h want %h/%h", cyc, rf_waddr_o, rf_wdata_o, m_waddr, m_wdata); end
         end
         checks++; if (error_o !== m_err || m_err) begin errors++; $display("FAIL rnd_error cyc%0d got %0b want 0", cyc, error_o); end
         checks++; if (byp1_hit_o !== exp_hit(src1_i) || byp2_hit_o !== exp_hit(src2_i)) begin
            errors++; $display("FAIL rnd_byp cyc%0d got %0b%0b want %0b%0b", cyc, byp1_hit_o, byp2_hit_o, exp_hit(src1_i), exp_hit(src2_i)); end
         ld_taken = ld_wb_valid_i && !fpu_wb_valid_i;
         tick();
         if (issued) inflight.push_back(d);
         if (ld_taken) begin
            ld_hold = 1'b0; ld_wb_valid_i = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_raw_hazard();
      test_arbitration();
      test_set_clear_same();
      test_double_issue();
      test_load_nonbusy();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
